residue_acc_mod3: RTL and testbench



---
 rtl/residue_pkg.sv | 25 ++
 rtl/residue_acc_mod3_sb_delay.sv | 26 ++
 rtl/residue_acc_mod3.sv | 104 ++++++++++
 tb/tb_residue_acc_mod3.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/residue_pkg.sv
// Shared types and helpers for the mod-3 residue accumulator.
package residue_pkg;

  typedef logic [1:0] res3_t;

  localparam int RES_MOD = 3;
  localparam int DIV_LAT = 2;

  typedef struct packed {
    logic vld;
    logic last;
  } sb_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  // General for any two 2-bit inputs, so a stray 3 folds to 0.
  function automatic res3_t add_mod3(res3_t a, res3_t b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'(2 * RES_MOD))  s = s - 3'(2 * RES_MOD);
    else if (s >= 3'(RES_MOD)) s = s - 3'(RES_MOD);
    return s[1:0];
  endfunction

endpackage

// File: rtl/residue_acc_mod3_sb_delay.sv
// Sideband shift register: delays {valid, last} by DEPTH cycles, async clear.
import residue_pkg::*;

module sb_delay #(
  parameter int DEPTH = DIV_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  sb_t  d,
  output sb_t  q
);

  sb_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/residue_acc_mod3.sv
// Folds per-word mod-3 remainders into a per-message residue with a 1-deep output.
// Optional illegal-remainder check: define RESIDUE_ACC_ERRCHK_EN.
import residue_pkg::*;

module residue_acc_mod3 #(
  parameter int SB_LAT = DIV_LAT,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [1:0]       in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_r,
  output logic             out_div3,
  output logic [CNT_W-1:0] out_words,
  output logic             busy,
  output logic             ovf
`ifdef RESIDUE_ACC_ERRCHK_EN
  , output logic           err_illegal
`endif
);

  sb_t sb_in, sb_a;
  assign sb_in = '{vld: in_valid, last: in_last};

  sb_delay #(.DEPTH(SB_LAT)) u_sb (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sb_in),
    .q    (sb_a)
  );

  state_t           state, state_n;
  res3_t            acc, acc_n, sum;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             load;

  always_comb begin
    sum     = add_mod3((state == IDLE) ? res3_t'(0) : acc, in_r);
    cnt_inc = (state == IDLE) ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    load    = 1'b0;
    if (sb_a.vld) begin
      if (sb_a.last) begin
        load    = 1'b1;
        state_n = IDLE;
        acc_n   = '0;
        cnt_n   = '0;
      end else begin
        state_n = ACCUM;
        acc_n   = sum;
        cnt_n   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      busy  <= (state_n == ACCUM);
    end
  end

  // A load always wins over a clearing transfer in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_words <= '0;
      ovf       <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_r     <= sum;
        out_words <= cnt_inc;
        if (out_valid && !out_ready) ovf <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_div3 = (out_r == 2'd0);

`ifdef RESIDUE_ACC_ERRCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_illegal <= 1'b0;
    else if (sb_a.vld && in_r == 2'd3)  err_illegal <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_residue_acc_mod3.sv
// Scoreboard bench for residue_acc_mod3; models the 2-cycle divider in front of it.
module tb_residue_acc_mod3;

  localparam int CNT_W = 16;

  typedef struct {
    logic [1:0] r;
    int         words;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [1:0]       in_r;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_r;
  logic             out_div3;
  logic [CNT_W-1:0] out_words;
  logic             busy;
  logic             ovf;
`ifdef RESIDUE_ACC_ERRCHK_EN
  logic             err_illegal;
`endif

  logic [63:0] x_in = '0;
  logic [1:0]  r_d1 = '0, r_d2 = '0;
  logic        force3 = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Divider stand-in: not reset, so words in flight survive a reset of the DUT.
  always @(posedge clk) begin
    r_d1 <= 2'(x_in % 64'd3);
    r_d2 <= r_d1;
  end
  assign in_r = force3 ? 2'd3 : r_d2;

  residue_acc_mod3 #(.SB_LAT(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_r       (in_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_div3   (out_div3),
    .out_words  (out_words),
    .busy       (busy),
    .ovf        (ovf)
`ifdef RESIDUE_ACC_ERRCHK_EN
    , .err_illegal(err_illegal)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] r, input int words);
    exp_t e;
    e.r = r;
    e.words = words;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [63:0] x, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    x_in     = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got r=%0d words=%0d expected none", out_r, out_words);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_r", int'(out_r), int'(e.r));
        chk("out_div3", int'(out_div3), int'(e.r == 2'd0));
        chk("out_words", int'(out_words), e.words);
      end
    end
  end

  initial begin
    idle(3);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_div3", int'(out_div3), 1);
    chk("rst_out_words", int'(out_words), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
`ifdef RESIDUE_ACC_ERRCHK_EN
    chk("rst_err_illegal", int'(err_illegal), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // 5,7,4 -> 2+1+1 = 4 -> 1, three words; latency t+3
    push_exp(2'd1, 3);
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    send(64'd4, 1'b1);
    @(negedge clk);
    chk("lat_t1_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_t2_valid", int'(out_valid), 0);
    chk("busy_mid_msg", int'(busy), 1);
    @(negedge clk);
    chk("lat_t3_valid", int'(out_valid), 1);
    chk("busy_after_last", int'(busy), 0);
    idle(3);

    // 1,2 -> 0, two words
    push_exp(2'd0, 2);
    send(64'd1, 1'b0);
    send(64'd2, 1'b1);
    idle(5);

    // 2^64-1 is 0 mod 3
    push_exp(2'd0, 1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    idle(5);
    chk("ovf_clear_so_far", int'(ovf), 0);

    // Back-to-back single words with no ready: 8 (r=2) overwrites 4 (r=1)
    out_ready = 1'b0;
    send(64'd4, 1'b1);
    send(64'd8, 1'b1);
    idle(5);
    @(negedge clk);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_held_valid", int'(out_valid), 1);
    chk("ovf_held_r", int'(out_r), 2);
    @(posedge clk); #1;
    push_exp(2'd2, 1);
    out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("valid_cleared", int'(out_valid), 0);

    // Reset mid-message, then a fresh single word X=2
    send(64'd5, 1'b0);
    send(64'd7, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    chk("midrst_no_output", int'(out_valid), 0);
    push_exp(2'd2, 1);
    send(64'd2, 1'b1);
    idle(5);

`ifdef RESIDUE_ACC_ERRCHK_EN
    chk("err_before", int'(err_illegal), 0);
    force3 = 1'b1;
    push_exp(2'd0, 1);
    send(64'd1, 1'b1);
    idle(3);
    force3 = 1'b0;
    idle(4);
    @(negedge clk);
    chk("err_set", int'(err_illegal), 1);
    idle(5);
    @(negedge clk);
    chk("err_sticky", int'(err_illegal), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_rst", int'(err_illegal), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
`endif

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
